// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and control state type shared by the sequential ALU.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_MUL = 4'b1111;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

endpackage

// File: rtl/seq_mul.sv
// seq_mul: radix-2 shift-add multiplier producing the low WIDTH bits of a*b
// after exactly WIDTH iterations; done stays high until the next start.
module seq_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             hold,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;

    // One multiplier bit per cycle; frozen at the terminal count or while held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            count  <= '0;
        end else if (!hold && (count != LAST)) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
        end
    end

    assign done    = (count == LAST);
    assign product = acc;

endmodule

// File: rtl/seq_alu.sv
// seq_alu: execute-stage ALU with a registered valid/ready result port.
// Single-cycle ops load the output register on accept; MUL runs on seq_mul
// and stalls the front end through in_ready until its result is parked.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter bit MUL_EN = 1'b1
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    logic             slot_free;
    logic             accept;
    logic             is_mul;
    logic             mul_start;
    logic             mul_hold;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == IDLE) && slot_free;
    assign accept    = in_valid && in_ready;
    assign is_mul    = MUL_EN && (alu_op == ALU_MUL);
    assign mul_start = accept && is_mul;
    assign mul_hold  = (state != MUL_RUN);
    assign shamt     = b[SHW-1:0];

    generate
        if (MUL_EN) begin : g_mul
            seq_mul #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (mul_start),
                .hold    (mul_hold),
                .a       (a),
                .b       (b),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    // Single-cycle operation decode; unknown opcodes (and MUL here) yield zero
    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_AND: alu_res = a & b;
            ALU_OR:  alu_res = a | b;
            ALU_ADD: alu_res = a + b;
            ALU_SUB: alu_res = a - b;
            ALU_NOR: alu_res = ~(a | b);
            ALU_XOR: alu_res = a ^ b;
            ALU_SLL: alu_res = a << shamt;
            ALU_SRL: alu_res = a >> shamt;
            ALU_SRA: alu_res = $signed(a) >>> shamt;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_res = '0;
        endcase
    end

    // Control FSM and output register: a transfer empties the slot unless a new result lands on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            busy      <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state <= MUL_RUN;
                            busy  <= 1'b1;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            out_valid <= 1'b1;
                        end
                    end
                end
                MUL_RUN: begin
                    if (mul_done && slot_free) begin
                        result    <= mul_product;
                        zero      <= (mul_product == '0);
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and randomized checks of seq_alu (WIDTH=64) against
// an operation-level reference model kept in the bench.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W        = 64;
    localparam int MAX_WAIT = 200;
    localparam int MUL_LAT  = W + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   alu_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         busy;

    int checks = 0;
    int errors = 0;

    // Model state: the output slot, and a pending multiply counting down edges
    logic         m_valid;
    logic [W-1:0] m_result;
    logic         m_busy;
    int           m_left;
    logic [W-1:0] m_mul_val;

    seq_alu #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Reference result of one operation, straight from the opcode table
    function automatic logic [W-1:0] ref_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        int           s;
        logic [W-1:0] ones;
        s    = int'(y % W);
        ones = '1;
        case (op)
            ALU_AND: return x & y;
            ALU_OR:  return x | y;
            ALU_ADD: return x + y;
            ALU_SUB: return x - y;
            ALU_NOR: return ~(x | y);
            ALU_XOR: return x ^ y;
            ALU_SLL: return x << s;
            ALU_SRL: return x >> s;
            ALU_SRA: return (x >> s) | (x[W-1] ? ~(ones >> s) : {W{1'b0}});
            ALU_SLT: return W'($signed(x) < $signed(y));
            ALU_MUL: return x * y;
            default: return '0;
        endcase
    endfunction

    // Operand generator biased towards edge values
    function automatic logic [W-1:0] randOperand();
        logic [W-1:0] v;
        case ($urandom_range(0, 4))
            0:       v = {$urandom, $urandom};
            1:       v = W'($urandom_range(0, 70));
            2:       v = {1'b1, {(W-1){1'b0}}} | W'($urandom_range(0, 255));
            3:       v = '1;
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Present one operation and hold it until the edge that accepts it
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        n        = 0;
        alu_op   = op;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        while (!in_ready && n < MAX_WAIT) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("accept_wait", W'(n < MAX_WAIT), W'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid; an expired bound is a failed comparison
    task automatic waitOutput(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < MAX_WAIT) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL out_valid_timeout: got 0 expected 1 after %0d cycles", cycles);
        end
    endtask

    task automatic runOp(input string name, input logic [3:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] exp);
        int c;
        out_ready = 1'b1;
        applyStimulus(op, x, y);
        waitOutput(c);
        checkOutput(name, result, exp);
        checkOutput({name, "_zero"}, W'(zero), W'(exp == '0));
    endtask

    // Every cycle: compare DUT outputs with the model, then advance the model with the inputs of the coming edge
    always @(negedge clk) begin
        logic exp_ready;
        logic slot_free;
        logic take;
        if (!rst_n) begin
            m_valid  = 1'b0;
            m_result = '0;
            m_busy   = 1'b0;
            m_left   = 0;
        end
        exp_ready = !m_busy && (!m_valid || out_ready);
        checkOutput("out_valid", W'(out_valid), W'(m_valid));
        checkOutput("busy", W'(busy), W'(m_busy));
        checkOutput("in_ready", W'(in_ready), W'(exp_ready));
        if (m_valid || !rst_n) begin
            checkOutput("result", result, m_result);
            checkOutput("zero", W'(zero), W'(m_result == '0));
        end
        if (rst_n) begin
            slot_free = !m_valid || out_ready;
            take      = in_valid && exp_ready;
            if (m_valid && out_ready) m_valid = 1'b0;
            if (m_busy) begin
                if (m_left > 1) begin
                    m_left--;
                end else if (slot_free) begin
                    m_valid  = 1'b1;
                    m_result = m_mul_val;
                    m_busy   = 1'b0;
                end
            end else if (take) begin
                if (alu_op == ALU_MUL) begin
                    m_busy    = 1'b1;
                    m_left    = MUL_LAT;
                    m_mul_val = a * b;
                end else begin
                    m_valid  = 1'b1;
                    m_result = ref_op(alu_op, a, b);
                end
            end
        end
    end

    // Hard stop if anything hangs
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        int bad;
        logic [W-1:0] ma;
        logic [W-1:0] mb;
        logic [4:0]   r;

        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        alu_op    = ALU_AND;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;

        // Reset: outputs at reset values, in_ready high, offered ops ignored
        alu_op   = ALU_ADD;
        a        = W'(1);
        b        = W'(1);
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", W'(out_valid), W'(0));
        checkOutput("rst_result", result, W'(0));
        checkOutput("rst_zero", W'(zero), W'(1));
        checkOutput("rst_busy", W'(busy), W'(0));
        checkOutput("rst_in_ready", W'(in_ready), W'(1));
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Directed single-cycle operations with hand-computed results
        runOp("add", ALU_ADD, W'(5), W'(3), W'(8));
        runOp("sub", ALU_SUB, W'(16), W'(16), W'(0));
        runOp("nor", ALU_NOR, W'(0), W'(0), {W{1'b1}});
        runOp("xor", ALU_XOR, W'(64'hF0F0), W'(64'hFF00), W'(64'h0FF0));
        runOp("sll", ALU_SLL, W'(1), W'(64'h45), W'(64'h20));
        runOp("sra", ALU_SRA, 64'h8000_0000_0000_0000, W'(4), 64'hF800_0000_0000_0000);
        runOp("srl", ALU_SRL, 64'h8000_0000_0000_0000, W'(4), 64'h0800_0000_0000_0000);
        runOp("slt_neg", ALU_SLT, {W{1'b1}}, W'(1), W'(1));
        runOp("slt_pos", ALU_SLT, W'(1), {W{1'b1}}, W'(0));
        runOp("undef_op", 4'b0100, W'(5), W'(3), W'(0));

        // Multiply: exact latency, busy high and in_ready low throughout
        out_ready = 1'b1;
        applyStimulus(ALU_MUL, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        c   = 0;
        bad = 0;
        while (!out_valid && c < MAX_WAIT) begin
            if (!busy || in_ready) bad++;
            @(posedge clk); #1;
            c++;
        end
        checkOutput("mul_latency", W'(c), W'(MUL_LAT));
        checkOutput("mul_busy_stall", W'(bad), W'(0));
        checkOutput("mul_result", result, 64'hFFFF_FFFE_0000_0001);
        @(posedge clk); #1;

        // Back-to-back single-cycle ops with the consumer always ready
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            alu_op   = (i % 2 == 0) ? ALU_ADD : ALU_XOR;
            a        = randOperand();
            b        = randOperand();
            in_valid = 1'b1;
            #1;
            if (!in_ready) bad++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checkOutput("throughput_ready", W'(bad), W'(0));
        @(posedge clk); #1;

        // Back-pressure: ADD held, then leaves as MUL is accepted; MUL result held until taken
        out_ready = 1'b0;
        applyStimulus(ALU_ADD, W'(100), W'(23));
        repeat (5) begin
            @(posedge clk); #1;
        end
        checkOutput("bp_add_held", result, W'(123));
        checkOutput("bp_add_valid", W'(out_valid), W'(1));
        out_ready = 1'b1;
        applyStimulus(ALU_MUL, W'(64'h12345), W'(64'h1000));
        out_ready = 1'b0;
        waitOutput(c);
        repeat (10) begin
            @(posedge clk); #1;
        end
        checkOutput("bp_mul_held", result, W'(64'h1234_5000));
        checkOutput("bp_mul_valid", W'(out_valid), W'(1));
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_mul_taken", W'(out_valid), W'(0));

        // Reset at iteration 10 of a multiply aborts it
        applyStimulus(ALU_MUL, W'(7), W'(9));
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", W'(out_valid), W'(0));
        checkOutput("abort_busy", W'(busy), W'(0));
        checkOutput("abort_in_ready", W'(in_ready), W'(1));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (70) begin
            @(posedge clk); #1;
        end
        runOp("add_after_abort", ALU_ADD, W'(40), W'(2), W'(42));

        // Randomized traffic; the per-cycle model check does the scoring
        for (int i = 0; i < 2500; i++) begin
            r        = 5'($urandom_range(0, 15));
            alu_op   = r[3:0];
            if (alu_op == ALU_MUL && $urandom_range(0, 3) != 0) alu_op = ALU_SUB;
            ma       = randOperand();
            mb       = randOperand();
            a        = ma;
            b        = mb;
            in_valid = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (80) begin
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
